tx_buf_sched: RTL

- Schedules transmission of completed TX buffer slots between the message writer (command decoder / ADC packetiser) and the USB output engine.
- Tracks per-slot full/empty ownership of the ping-pong packet buffer and queues completed slots in completion order.
- The handshake slot always has priority over data slots.
- Back-pressures the writer when no data slot is free, and counts overruns.

---
 rtl/tx_buf_sched_pkg.sv | 14 +
 rtl/tx_buf_sched_if.sv | 31 +++
 rtl/tx_buf_sched_fifo.sv | 50 +++++
 rtl/tx_buf_sched.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/tx_buf_sched_pkg.sv
// Shared types and defaults for the TX buffer scheduler.
package tx_buf_sched_pkg;

    localparam int unsigned BUFFER_BADDR_NBIT = 2;
    localparam int unsigned TX_SCHED_HS_BADDR = 0;

    typedef enum logic [1:0] {
        ST_SCHED_IDLE    = 2'd0,
        ST_SCHED_ISSUE   = 2'd1,
        ST_SCHED_BUSY    = 2'd2,
        ST_SCHED_RELEASE = 2'd3
    } sched_state_e;

endpackage

// File: rtl/tx_buf_sched_if.sv
// Writer / USB-engine facing signals of the TX buffer scheduler.
interface tx_buf_sched_if
    import tx_buf_sched_pkg::*;
#(
    parameter int unsigned BADDR_NBIT = BUFFER_BADDR_NBIT,
    parameter int unsigned OVF_NBIT   = 8
);
    localparam int unsigned NSLOT = 2 ** BADDR_NBIT;

    logic                  wr_done;
    logic [BADDR_NBIT-1:0] wr_baddr;
    logic                  wr_ready;
    logic [NSLOT-1:0]      free_mask;
    logic                  rd_req;
    logic [BADDR_NBIT-1:0] rd_baddr;
    logic                  rd_ack;
    logic                  rd_done;
    logic [OVF_NBIT-1:0]   ovf_cnt;
    logic                  timeout_err;

    modport master (
        output wr_done, wr_baddr, rd_ack, rd_done,
        input  wr_ready, free_mask, rd_req, rd_baddr, ovf_cnt, timeout_err
    );

    modport slave (
        input  wr_done, wr_baddr, rd_ack, rd_done,
        output wr_ready, free_mask, rd_req, rd_baddr, ovf_cnt, timeout_err
    );

endinterface

// File: rtl/tx_buf_sched_fifo.sv
// Completion-order FIFO of data slot indices; caller never pushes when full or pops when empty.
module tx_buf_sched_fifo #(
    parameter int unsigned AW = 2,
    parameter int unsigned DW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic          empty,
    output logic [DW-1:0] dout
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign empty = (count == '0);
    assign dout  = mem[rptr];

endmodule

// File: rtl/tx_buf_sched.sv
// Schedules completed TX buffer slots to the USB engine, handshake slot first.
// Define TX_SCHED_TIMEOUT_EN to add a BUSY watchdog that force-releases a stuck slot.
module tx_buf_sched
    import tx_buf_sched_pkg::*;
#(
    parameter int unsigned BADDR_NBIT  = BUFFER_BADDR_NBIT,
    parameter int unsigned HS_BADDR    = TX_SCHED_HS_BADDR,
    parameter int unsigned OVF_NBIT    = 8,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input logic           mclk,
    input logic           rst,
    tx_buf_sched_if.slave bus
);
    localparam int unsigned           NSLOT     = 2 ** BADDR_NBIT;
    localparam logic [BADDR_NBIT-1:0] HS_IDX    = BADDR_NBIT'(HS_BADDR);
    localparam logic [NSLOT-1:0]      DATA_MASK = ~(NSLOT'(1) << HS_BADDR);

    sched_state_e          state, state_nxt;
    logic [NSLOT-1:0]      full, full_nxt;
    logic                  hs_pend;
    logic                  wr_v;
    logic [BADDR_NBIT-1:0] wr_s;
    logic                  release_now, slot_free, set_ok, overrun, push, pop, hs_take;
    logic                  rd_req_nxt;
    logic [BADDR_NBIT-1:0] rd_baddr_nxt;
    logic                  fifo_empty;
    logic [BADDR_NBIT-1:0] fifo_dout;
    logic                  to_expire;

    tx_buf_sched_fifo #(
        .AW (BADDR_NBIT),
        .DW (BADDR_NBIT)
    ) u_fifo (
        .clk   (mclk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (wr_s),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    // A slot being released this cycle counts as empty, so a coincident completion re-fills it.
    always_comb begin
        release_now = (state == ST_SCHED_RELEASE);
        slot_free   = ~full[wr_s] | (release_now & (bus.rd_baddr == wr_s));
        set_ok      = wr_v & slot_free;
        overrun     = wr_v & ~slot_free;
        push        = set_ok & (wr_s != HS_IDX);
        full_nxt    = full;
        if (release_now) begin
            full_nxt[bus.rd_baddr] = 1'b0;
        end
        if (set_ok) begin
            full_nxt[wr_s] = 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        rd_req_nxt   = bus.rd_req;
        rd_baddr_nxt = bus.rd_baddr;
        pop          = 1'b0;
        hs_take      = 1'b0;
        case (state)
            ST_SCHED_IDLE: begin
                if (hs_pend) begin
                    hs_take      = 1'b1;
                    rd_baddr_nxt = HS_IDX;
                    rd_req_nxt   = 1'b1;
                    state_nxt    = ST_SCHED_ISSUE;
                end else if (!fifo_empty) begin
                    pop          = 1'b1;
                    rd_baddr_nxt = fifo_dout;
                    rd_req_nxt   = 1'b1;
                    state_nxt    = ST_SCHED_ISSUE;
                end
            end
            ST_SCHED_ISSUE: begin
                if (bus.rd_ack) begin
                    rd_req_nxt = 1'b0;
                    state_nxt  = ST_SCHED_BUSY;
                end
            end
            ST_SCHED_BUSY: begin
                if (bus.rd_done || to_expire) begin
                    state_nxt = ST_SCHED_RELEASE;
                end
            end
            ST_SCHED_RELEASE: state_nxt = ST_SCHED_IDLE;
            default:          state_nxt = ST_SCHED_IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state         <= ST_SCHED_IDLE;
            full          <= '0;
            hs_pend       <= 1'b0;
            wr_v          <= 1'b0;
            wr_s          <= '0;
            bus.rd_req    <= 1'b0;
            bus.rd_baddr  <= '0;
            bus.ovf_cnt   <= '0;
            bus.free_mask <= '1;
            bus.wr_ready  <= (NSLOT > 1);
        end else begin
            state         <= state_nxt;
            full          <= full_nxt;
            hs_pend       <= (hs_pend & ~hs_take) | (set_ok & (wr_s == HS_IDX));
            wr_v          <= bus.wr_done;
            wr_s          <= bus.wr_baddr;
            bus.rd_req    <= rd_req_nxt;
            bus.rd_baddr  <= rd_baddr_nxt;
            if (overrun && (bus.ovf_cnt != '1)) begin
                bus.ovf_cnt <= bus.ovf_cnt + 1'b1;
            end
            bus.free_mask <= ~full;
            bus.wr_ready  <= |(~full & DATA_MASK);
        end
    end

`ifdef TX_SCHED_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] to_cnt;

    assign to_expire = (to_cnt == TO_LAST);

    always_ff @(posedge mclk) begin
        if (rst) begin
            to_cnt          <= '0;
            bus.timeout_err <= 1'b0;
        end else begin
            if (state == ST_SCHED_ISSUE) begin
                to_cnt <= '0;
            end else if (state == ST_SCHED_BUSY) begin
                to_cnt <= to_cnt + 1'b1;
            end
            bus.timeout_err <= (state == ST_SCHED_BUSY) && !bus.rd_done && to_expire;
        end
    end
`else
    assign to_expire       = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

endmodule
